// File: rtl/spi_target_pkg.sv
// spi_target_pkg: state encoding and shared constants for the SPI target register file
package spi_target_pkg;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, WRITE, READ} state_t;
  localparam logic CMD_WRITE_BIT = 1'b1;
  function automatic int status_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises SCLK/CS/PICO and derives sample/shift edge and CS edge pulses
module spi_pin_sync #(
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic pico,
  output logic cs_s,
  output logic pico_s,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise
);
  localparam logic IDLE_LVL = CPOL != 0;
  localparam logic SAMPLE_RISE = CPOL == CPHA;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, pico_q;
  logic sclk_d, cs_d, rise, fall;
  // CS resets low so a CS held low through reset never produces a falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= {SYNC_STAGES{IDLE_LVL}};
      cs_q <= '0;
      pico_q <= '0;
      sclk_d <= IDLE_LVL;
      cs_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q <= {cs_q[SYNC_STAGES-2:0], cs};
      pico_q <= {pico_q[SYNC_STAGES-2:0], pico};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d <= cs_q[SYNC_STAGES-1];
    end
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign pico_s = pico_q[SYNC_STAGES-1];
  assign rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign sample_edge = ~cs_s & (SAMPLE_RISE ? rise : fall);
  assign shift_edge = ~cs_s & (SAMPLE_RISE ? fall : rise);
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
endmodule

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI target decoding burst reads/writes of a register file plus a status word
module spi_target_regfile
  import spi_target_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int NUM_REGS = 16,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         sys_clock_i,
  input  logic                         sys_reset_ni,
  input  logic                         spi_clock_i,
  input  logic                         spi_cs_i,
  input  logic                         spi_pico_i,
  output logic                         spi_poci_o,
  output logic                         spi_poci_oe_o,
  input  logic [DATA_W-1:0]            status_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_strobe_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         frame_active_o
);
  localparam int SH_W = DATA_W > ADDR_W + 1 ? DATA_W : ADDR_W + 1;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_A = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(status_addr(ADDR_W));
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  state_t state, state_nx;
  logic cs_s, pico_s, sample_edge, shift_edge, cs_fall, cs_rise;
  logic busy, last_bit;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-2:0] rx;
  logic [SH_W-1:0] rx_nx;
  logic [DATA_W-1:0] tx, ld_data;
  logic [ADDR_W-1:0] addr, ld_addr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  spi_pin_sync #(.CPOL(CPOL), .CPHA(CPHA), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(sys_clock_i),
    .rst_n(sys_reset_ni),
    .sclk(spi_clock_i),
    .cs(spi_cs_i),
    .pico(spi_pico_i),
    .cs_s(cs_s),
    .pico_s(pico_s),
    .sample_edge(sample_edge),
    .shift_edge(shift_edge),
    .cs_fall(cs_fall),
    .cs_rise(cs_rise)
  );

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

  always_comb begin
    busy = state inside {CMD, WRITE, READ};
    rx_nx = {rx, pico_s};
    last_bit = sample_edge && busy && cnt == (state == CMD ? CMD_LAST : DATA_LAST);
    ld_addr = state == CMD ? rx_nx[ADDR_W-1:0] : addr + 1'b1;
    ld_data = ld_addr < NUM_A ? regs[ld_addr[IDX_W-1:0]] : ld_addr == STAT_A ? status_i : '0;
    state_nx = state == WAIT_IDLE ? (cs_s ? IDLE : WAIT_IDLE) :
               cs_rise ? IDLE :
               (state == IDLE && cs_fall) ? CMD :
               (state == CMD && last_bit) ? (rx_nx[ADDR_W] == CMD_WRITE_BIT ? WRITE : READ) :
               state;
  end

  always_ff @(posedge sys_clock_i or negedge sys_reset_ni)
    if (!sys_reset_ni) begin
      state <= WAIT_IDLE;
      cnt <= '0;
      rx <= '0;
      tx <= '0;
      addr <= '0;
      spi_poci_o <= 1'b0;
      spi_poci_oe_o <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o <= '0;
      frame_active_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      frame_active_o <= state_nx inside {CMD, WRITE, READ};
      spi_poci_oe_o <= state_nx == READ;
      wr_strobe_o <= 1'b0;
      if (cs_fall) cnt <= '0;
      else if (sample_edge && busy) begin
        rx <= rx_nx[SH_W-2:0];
        cnt <= last_bit ? '0 : cnt + 1'b1;
      end
      if (state == CMD && last_bit) addr <= rx_nx[ADDR_W-1:0];
      if ((state == WRITE || state == READ) && last_bit) addr <= addr + 1'b1;
      if (state == WRITE && last_bit && addr < NUM_A) begin
        regs[addr[IDX_W-1:0]] <= rx_nx[DATA_W-1:0];
        wr_strobe_o <= 1'b1;
        wr_addr_o <= addr;
      end
      // the first shift edge after a load is skipped: the MSB is already on the pin
      if (state_nx == READ && last_bit) begin
        spi_poci_o <= ld_data[DATA_W-1];
        tx <= ld_data << 1;
      end else if (state == READ && shift_edge && cnt != '0) begin
        spi_poci_o <= tx[DATA_W-1];
        tx <= tx << 1;
      end else if (state_nx != READ) spi_poci_o <= 1'b0;
    end
endmodule

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: scoreboard bench acting as SPI controller for modes (0,0), (1,1), (0,1)
module tb_spi_target_regfile;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] sclk = 3'b010;
  logic [2:0] cs = 3'b111;
  logic pico = 1'b0;
  logic [7:0] status = 8'h00;
  logic poci [3];
  logic oe [3];
  logic strobe [3];
  logic fa [3];
  logic [6:0] waddr [3];
  logic [127:0] regs [3];
  logic [7:0] mdl [3][16];
  logic [8:0] exp_wr [$];
  logic [7:0] exp_rd [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_target_regfile #(.CPOL(g == 1 ? 1 : 0), .CPHA(g == 0 ? 0 : 1)) dut (
      .sys_clock_i(clk),
      .sys_reset_ni(rst_n),
      .spi_clock_i(sclk[g]),
      .spi_cs_i(cs[g]),
      .spi_pico_i(pico),
      .spi_poci_o(poci[g]),
      .spi_poci_oe_o(oe[g]),
      .status_i(status),
      .regs_o(regs[g]),
      .wr_strobe_o(strobe[g]),
      .wr_addr_o(waddr[g]),
      .frame_active_o(fa[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input int m);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = mdl[m][k];
    return r;
  endfunction

  always @(negedge clk)
    for (int m = 0; m < 3; m++)
      if (strobe[m]) begin
        if (exp_wr.size() == 0) check("wr_unexpected", strobe[m], 1'b0);
        else check("wr_addr", {m[1:0], waddr[m]}, exp_wr.pop_front());
      end

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic xfer(input int m, input logic [7:0] tx, input int nb,
                      output logic [7:0] rx, output logic oe_any, output logic oe_all);
    logic cp;
    cp = (m == 1);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nb; i--) begin
      if (m == 0) begin
        pico = tx[i];
        wait_h();
        rx[i] = poci[m];
        oe_any |= oe[m];
        oe_all &= oe[m];
        sclk[m] = ~cp;
        wait_h();
        sclk[m] = cp;
      end else begin
        sclk[m] = ~cp;
        pico = tx[i];
        wait_h();
        rx[i] = poci[m];
        oe_any |= oe[m];
        oe_all &= oe[m];
        sclk[m] = cp;
        wait_h();
      end
    end
  endtask

  task automatic end_frame(input int m);
    wait_h();
    cs[m] = 1'b1;
    wait_h();
    wait_h();
    check("wr_pending", exp_wr.size(), 0);
    check("regs", regs[m], pack(m));
    check("frame_active_idle", fa[m], 1'b0);
    check("poci_oe_idle", oe[m], 1'b0);
  endtask

  task automatic frame(input int m, input logic [7:0] cmd, input int n, input logic [15:0] data);
    logic [7:0] rx, b;
    logic oa, ol;
    logic [6:0] a;
    a = cmd[6:0];
    cs[m] = 1'b0;
    wait_h();
    xfer(m, cmd, 8, rx, oa, ol);
    check("cmd_oe", oa, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = data[15 - 8*i -: 8];
      if (cmd[7]) begin
        if (a < 7'd16) begin
          exp_wr.push_back({2'(m), a});
          mdl[m][a[3:0]] = b;
        end
        xfer(m, b, 8, rx, oa, ol);
      end else begin
        exp_rd.push_back(a < 7'd16 ? mdl[m][a[3:0]] : a == 7'h7F ? status : 8'h00);
        xfer(m, 8'h00, 8, rx, oa, ol);
        check("rd_data", rx, exp_rd.pop_front());
        check("rd_oe", ol, 1'b1);
      end
      a++;
    end
    end_frame(m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic oa, ol;
    for (int m = 0; m < 3; m++)
      for (int k = 0; k < 16; k++) mdl[m][k] = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_poci", poci[0], 1'b0);
    check("rst_oe", oe[0], 1'b0);
    check("rst_strobe", strobe[0], 1'b0);
    check("rst_active", fa[0], 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      check("rst_regs", regs[m], 128'h0);
      check("rst_wr_addr", waddr[m], 7'h0);
    end
    for (int m = 0; m < 3; m++) begin
      frame(m, 8'h83, 2, 16'hA53C);
      frame(m, 8'h03, 2, 16'h0000);
    end
    frame(0, 8'h8F, 2, 16'h1122);
    frame(0, 8'h0F, 2, 16'h0000);
    status = 8'h5A;
    frame(0, 8'h7F, 1, 16'h0000);
    frame(0, 8'hFF, 1, 16'h0000);
    cs[0] = 1'b0;
    wait_h();
    xfer(0, 8'h85, 8, rx, oa, ol);
    xfer(0, 8'hFF, 5, rx, oa, ol);
    end_frame(0);
    cs[0] = 1'b0;
    wait_h();
    xfer(0, 8'h80, 8, rx, oa, ol);
    xfer(0, 8'hEE, 3, rx, oa, ol);
    rst_n = 1'b0;
    wait_h();
    rst_n = 1'b1;
    for (int m = 0; m < 3; m++)
      for (int k = 0; k < 16; k++) mdl[m][k] = 8'h00;
    wait_h();
    check("midreset_regs", regs[0], 128'h0);
    xfer(0, 8'h80, 8, rx, oa, ol);
    xfer(0, 8'hEE, 8, rx, oa, ol);
    check("no_decode_active", fa[0], 1'b0);
    end_frame(0);
    frame(0, 8'h80, 1, 16'h7700);
    frame(0, 8'h00, 1, 16'h0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
